// File: rtl/mask_enc_pkg.sv
// Shared widths and FSM state type for the 32-to-5 sequential mask encoder.
package mask_enc_pkg;

  localparam int ENC_W     = 32;
  localparam int ENC_IDX_W = 5;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } mask_enc_state_t;

endpackage

// File: rtl/mask_encoder32_5_priority_enc.sv
// Combinational 32-to-5 priority encoder (module priority_enc32_5): four 8-to-3 groups and a 4-to-2 group select.
// MASK_ENC_DESCENDING_EN selects the highest set bit instead of the lowest.
module priority_enc32_5
  import mask_enc_pkg::*;
(
  input  logic [ENC_W-1:0]     vec,
  output logic [ENC_IDX_W-1:0] idx,
  output logic                 any
);

  logic [ENC_W-1:0]     scan_vec;
  logic [3:0]           grp_any;
  logic [3:0][2:0]      grp_idx;
  logic [1:0]           grp_sel;
  logic [ENC_IDX_W-1:0] asc_idx;

`ifdef MASK_ENC_DESCENDING_EN
  // Reversing the input turns "highest set bit" into "lowest set bit".
  always_comb begin
    scan_vec = '0;
    for (int i = 0; i < ENC_W; i++) scan_vec[i] = vec[ENC_W-1-i];
  end
  assign idx = any ? (ENC_IDX_W'(ENC_W - 1) - asc_idx) : '0;
`else
  assign scan_vec = vec;
  assign idx      = any ? asc_idx : '0;
`endif

  // NOTE: every always_comb output gets a default before any conditional
  // assignment; a path that leaves it unassigned would infer a latch.
  always_comb begin
    grp_any = '0;
    grp_idx = '0;
    grp_sel = '0;
    for (int g = 0; g < 4; g++) begin
      grp_any[g] = |scan_vec[8*g +: 8];
      // Walk downwards so the lowest set bit is the last one written.
      for (int b = 7; b >= 0; b--) begin
        if (scan_vec[8*g + b]) grp_idx[g] = 3'(b);
      end
    end
    for (int g = 3; g >= 0; g--) begin
      if (grp_any[g]) grp_sel = 2'(g);
    end
  end

  assign asc_idx = {grp_sel, grp_idx[grp_sel]};
  assign any     = |grp_any;

endmodule

// File: rtl/mask_encoder32_5.sv
// Sequential 32-to-5 mask encoder: emits the index of every set bit of a loaded mask,
// one per out handshake. MASK_ENC_DESCENDING_EN reverses the emission order.
module mask_encoder32_5
  import mask_enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ENC_W-1:0]     in_mask,
  input  logic                 abort,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ENC_IDX_W-1:0] out_idx,
  output logic                 done,
  output logic                 busy
);

  mask_enc_state_t  state_q, state_d;
  logic [ENC_W-1:0] pending_q, pending_d;
  logic             done_q, done_d;
  logic             pend_any;
  logic [ENC_W-1:0] sel_bit;

  priority_enc32_5 u_prio (
    .vec (pending_q),
    .idx (out_idx),
    .any (pend_any)
  );

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SCAN);
  assign out_valid = (state_q == SCAN) && pend_any;
  assign done      = done_q;

  always_comb begin
    sel_bit          = '0;
    sel_bit[out_idx] = 1'b1;
    state_d          = state_q;
    pending_d        = pending_q;
    done_d           = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid && !abort) begin
          pending_d = in_mask;
          if (in_mask != '0) state_d = SCAN;
          else               done_d  = 1'b1;
        end
      end
      SCAN: begin
        // Abort wins over a simultaneous handshake: the index is not consumed.
        if (abort) begin
          pending_d = '0;
          state_d   = IDLE;
        end else if (out_ready) begin
          pending_d = pending_q & ~sel_bit;
          if (pending_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      pending_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      done_q    <= done_d;
    end
  end

endmodule

// File: tb/tb_mask_encoder32_5.sv
// Self-checking bench for mask_encoder32_5: directed steps plus random masks against a
// set-bit-list reference model (order follows MASK_ENC_DESCENDING_EN).
module tb_mask_encoder32_5;
  import mask_enc_pkg::*;

  typedef int idx_q_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_mask;
  logic        abort;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        done;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mask_encoder32_5 dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mask   (in_mask),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .done      (done),
    .busy      (busy)
  );

  // Reference: the list of set-bit positions in emission order.
  function automatic idx_q_t expected_order(input logic [31:0] m);
    idx_q_t q;
    q = {};
`ifdef MASK_ENC_DESCENDING_EN
    for (int i = 31; i >= 0; i--) if (m[i]) q.push_back(i);
`else
    for (int i = 0; i < 32; i++) if (m[i]) q.push_back(i);
`endif
    return q;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Loads a mask, optionally stalls the consumer, then drains and checks every index.
  // Returns in the done cycle so a caller can load the next mask back-to-back.
  task automatic run_mask(input logic [31:0] m, input int hold, input bit rand_ready);
    idx_q_t q;
    int     guard;
    q     = expected_order(m);
    guard = 0;
    while (!in_ready && guard < 64) begin
      tick();
      guard++;
    end
    check("load_ready", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    in_mask   = m;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    in_mask  = $urandom;
    if (q.size() == 0) begin
      check("zero_done", {31'd0, done}, 32'd1);
      check("zero_no_valid", {31'd0, out_valid}, 32'd0);
      check("zero_in_ready", {31'd0, in_ready}, 32'd1);
      return;
    end
    for (int h = 0; h < hold; h++) begin
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_idx", {27'd0, out_idx}, q[0]);
      check("hold_busy", {31'd0, busy}, 32'd1);
      tick();
    end
    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid  = rand_ready ? 1'($urandom_range(0, 1)) : 1'b0;
      check("scan_valid", {31'd0, out_valid}, 32'd1);
      check("scan_idx", {27'd0, out_idx}, q[0]);
      check("scan_done_low", {31'd0, done}, 32'd0);
      check("scan_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
      if (out_ready) void'(q.pop_front());
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("scan_remaining", q.size(), 32'd0);
    check("end_done", {31'd0, done}, 32'd1);
    check("end_valid", {31'd0, out_valid}, 32'd0);
    check("end_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic finish_idle();
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idx_q_t      q;
    logic [31:0] m;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_mask   = '0;
    abort     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_idx", {27'd0, out_idx}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    // Reset mid-scan after two indices.
    q         = expected_order(32'h0000_00F0);
    in_valid  = 1'b1;
    in_mask   = 32'h0000_00F0;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("midrst_idx0", {27'd0, out_idx}, q[0]);
    tick();
    check("midrst_idx1", {27'd0, out_idx}, q[1]);
    tick();
    check("midrst_idx2", {27'd0, out_idx}, q[2]);
    #2 reset = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_idx", {27'd0, out_idx}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    out_ready = 1'b0;
    tick();
    check("midrst_no_done", {31'd0, done}, 32'd0);
    check("midrst_idle", {31'd0, out_valid}, 32'd0);

    // Encode order and boundary bit 31.
    run_mask(32'h8000_0005, 0, 1'b0);
    finish_idle();

    // Backpressure holds the index.
    run_mask(32'h0000_0300, 3, 1'b0);
    finish_idle();

    // Zero mask, then a new mask loaded in the done cycle.
    run_mask(32'h0000_0000, 0, 1'b0);
    run_mask(32'h0000_0001, 0, 1'b0);
    finish_idle();

    // Abort after four indices with a simultaneous out_ready.
    q         = expected_order(32'hFFFF_FFFF);
    in_valid  = 1'b1;
    in_mask   = 32'hFFFF_FFFF;
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("abort_pre_idx", {27'd0, out_idx}, q[i]);
      tick();
    end
    abort = 1'b1;
    check("abort_cycle_valid", {31'd0, out_valid}, 32'd1);
    check("abort_cycle_idx", {27'd0, out_idx}, q[4]);
    tick();
    abort     = 1'b0;
    out_ready = 1'b0;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_in_ready", {31'd0, in_ready}, 32'd1);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_no_done", {31'd0, done}, 32'd0);
    check("abort_out_idx", {27'd0, out_idx}, 32'd0);
    tick();
    check("abort_no_done_late", {31'd0, done}, 32'd0);

    // Abort in IDLE wins over in_valid.
    abort    = 1'b1;
    in_valid = 1'b1;
    in_mask  = 32'h0000_0005;
    tick();
    abort    = 1'b0;
    in_valid = 1'b0;
    check("idle_abort_valid", {31'd0, out_valid}, 32'd0);
    check("idle_abort_busy", {31'd0, busy}, 32'd0);
    tick();
    check("idle_abort_done", {31'd0, done}, 32'd0);

    // Full mask and single-bit boundaries.
    run_mask(32'hFFFF_FFFF, 0, 1'b0);
    finish_idle();
    run_mask(32'h8000_0000, 0, 1'b0);
    finish_idle();
    run_mask(32'h0000_0001, 1, 1'b0);
    finish_idle();

    // Random masks with random backpressure and in_valid noise while scanning.
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0:       m = $urandom;
        1:       m = 32'h1 << $urandom_range(0, 31);
        2:       m = $urandom & $urandom & $urandom;
        default: m = $urandom_range(0, 1) ? 32'h0 : 32'hFFFF_FFFF;
      endcase
      run_mask(m, $urandom_range(0, 2), 1'b1);
      if ($urandom_range(0, 1) == 1) finish_idle();
    end
    finish_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mask_encoder32_5.md
# mask_encoder32_5

Sequential 32-to-5 encoder: the inverse of the register-file write-select decoder. It accepts a 32-bit mask (one bit per register or request line) and emits the 5-bit index of every set bit, one index per handshake, in ascending order by default. It sits in the CPU's multi-register transfer and pending-request paths, turning a mask back into register numbers that feed the 5-to-32 decoder or the register-file read ports.

## Interface
- Parameters: none. Widths come from package constants: `ENC_W = 32`, `ENC_IDX_W = 5`.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  mask offered
- in_ready  out  1  block can accept a mask (IDLE)
- in_mask  in  32  mask to encode; bit i means index i
- abort  in  1  synchronous cancel of the current mask
- out_valid  out  1  out_idx holds a valid index
- out_ready  in  1  consumer takes out_idx this cycle
- out_idx  out  5  index of the current selected set bit
- done  out  1  one-cycle pulse after a mask completes
- busy  out  1  high in SCAN

## Operation
- State machine with two states, IDLE and SCAN, plus a 32-bit `pending` register.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - When in_valid = 1, load `pending <= in_mask`.
  - If in_mask ≠ 0, go to SCAN.
  - If in_mask = 0, stay in IDLE and pulse done on the next cycle. No index is emitted.
- SCAN:
  - in_ready = 0, busy = 1, out_valid = 1.
  - out_idx = position of the lowest set bit of `pending` (combinational from the register).
  - On out_valid & out_ready, clear that bit in `pending`.
  - If the cleared bit was the last one, go to IDLE and pulse done for one cycle.
  - out_idx is held stable while out_ready = 0.
- abort:
  - In SCAN: clear `pending`, go to IDLE, no done pulse. This takes priority over a simultaneous out handshake, so the index is not counted as consumed.
  - In IDLE: a simultaneous in_valid is ignored.
- in_valid while in SCAN is not accepted because in_ready = 0. The mask is not lost; the upstream must hold it.
- Reset, asynchronous and valid at any time including mid-scan:
  - state = IDLE, pending = 0, done = 0.
  - Resulting outputs: out_valid = 0, busy = 0, in_ready = 1, out_idx = 0.

## Timing
- Load accepted at edge N → out_valid = 1 with the first index during cycle N+1.
- Throughput: one index per cycle when out_ready is held high. A mask with k set bits has its final handshake at edge N+k.
- done is registered: it is high for exactly the cycle after the final handshake (or after a zero-mask load).
- in_ready returns to 1 in the same cycle done is high. A new mask can be loaded on that edge, giving back-to-back masks with no idle bubble.
- Wrap and boundaries:
  - Bit 31 maps to out_idx = 31 with no overflow.
  - Mask 0xFFFFFFFF takes 32 handshakes.
  - A single-bit mask gives one index, then done.

## Configuration
- `MASK_ENC_DESCENDING_EN`
  - Defined: the scan selects the highest set bit first, so indices are emitted in descending order.
  - Undefined: lowest set bit first, ascending order.
- Handshake, latency and done behaviour are identical in both builds.

## Structure
- Package `mask_enc_pkg`:
  - `ENC_W`, `ENC_IDX_W`
  - state enum `mask_enc_state_t {IDLE, SCAN}`
- Sub-module `priority_enc32_5`: combinational, input 32-bit vector, outputs a 5-bit index and `any`.
  - Built hierarchically from 8-to-3 encoder groups plus a 4-to-2 group select, mirroring the decoder tree.
  - The descending build bit-reverses its input and then computes `31 - idx`.

## Test plan
- Reset mid-scan: load 0x0000_00F0, assert reset after 2 indices → out_valid = 0, in_ready = 1, out_idx = 0, and no done pulse.
- Ascending encode: load 0x8000_0005 with out_ready = 1 → out_idx 0, 2, 31 on consecutive cycles, then done for one cycle.
- Backpressure: load 0x0000_0300, out_ready = 0 for 3 cycles → out_idx holds 8; then 8, 9, done.
- Zero mask and back-to-back:
  - Load 0 → no out_valid, done one cycle later.
  - Load 0x1 in the done cycle → out_idx = 0 on the next cycle.
- Abort: load 0xFFFF_FFFF, abort with out_ready = 1 after 4 indices → IDLE, no done, in_ready = 1.
- `MASK_ENC_DESCENDING_EN` defined: load 0x8000_0005 → out_idx 31, 2, 0, then done.
